dynamic_preamble_filter: RTL and testbench
==========================================

DYNAMIC_PREAMBLE_FILTER -- requirements
Module: dynamic_preamble_filter

Interface
REQ-001 DATA_SIZE, default 48, width of input magnitude and output threshold.
REQ-002 MIN_POROG, default 1024, minimum threshold value (floor).
REQ-003 N_FILTR, default 5, log2 of averaging window length (window = 2^N_FILTR = 32 samples).
REQ-004 POROG_SHIFT, default 2, left-shift applied to window mean (threshold = mean x 4).
REQ-005 clk  input  1  single clock; all registers update on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  clock enable; when 0 every register holds its value.
REQ-008 in_data  input  DATA_SIZE  unsigned correlator magnitude (|corr|^2), one sample per enabled cycle.
REQ-009 out_porog  output  DATA_SIZE  unsigned dynamic detection threshold, registered.

Function
REQ-010 Block SHALL hold the last 2^N_FILTR accepted in_data samples in a window, oldest evicted on each accepted sample.
REQ-011 A sample SHALL be accepted on every rising clk edge with en=1 and reset high.
REQ-012 Running sum (DATA_SIZE+N_FILTR bits, no overflow possible) SHALL update on the accepting edge as sum + in_data - evicted sample.
REQ-013 Mean SHALL be sum >> N_FILTR (truncating).
REQ-014 Scaled value SHALL be mean << POROG_SHIFT computed at DATA_SIZE+POROG_SHIFT bits, saturated to 2^DATA_SIZE-1.
REQ-015 out_porog SHALL register max(MIN_POROG, saturated scaled value) on each enabled edge, derived from sum as held before that edge.
REQ-016 Latency: sample accepted at enabled edge t SHALL be reflected in out_porog after enabled edge t+1 (two enabled edges).
REQ-017 Until 2^N_FILTR samples are accepted, empty window slots SHALL count as zero (no special warm-up mode).
REQ-018 Window pointer SHALL wrap from 2^N_FILTR-1 to 0 without gap or duplicate eviction.
REQ-019 en=0 SHALL freeze window, pointer, sum and out_porog; in_data ignored.
REQ-020 out_porog SHALL never fall below MIN_POROG.

Reset
REQ-021 reset=0 SHALL asynchronously clear window contents, pointer and sum to 0 and set out_porog to MIN_POROG.
REQ-022 Reset asserted mid-operation SHALL discard all history; first accepted sample after release is treated as window sample 1.
REQ-023 No output SHALL depend on en during reset.

Structure
REQ-024 Parameter defaults and MIN/SHIFT helper constants SHALL reside in the shared OFDM receiver package; no typedefs required.
REQ-025 Window storage SHALL be one sub-module, dpf_window_mem (2^N_FILTR x DATA_SIZE circular buffer, write-and-read-oldest per enabled cycle); sum, scaling and floor logic in the top.

Verification
REQ-026 After reset, en=1, in_data=0 for 100 cycles -> out_porog stays 1024.
REQ-027 Step in_data 0->4096: after k accepted samples (plus one edge) out_porog = max(1024, 512k); equals 1024 at k=2, 16384 from k=32 onward.
REQ-028 32 samples of 4096 then zeros -> out_porog decreases 512 per sample (16384, 15872, ...), reaching 1024 at 30 zeros and staying 1024.
REQ-029 in_data = 2^48-1 constant for 40 samples -> out_porog saturates at 2^48-1, no wrap.
REQ-030 en=0 for 10 cycles while in_data changes -> out_porog and internal sum unchanged; resumes correctly when en=1.
REQ-031 reset pulsed low mid-ramp (out_porog=16384) -> out_porog=1024 immediately (asynchronous); subsequent ramp matches REQ-027 from k=1.

Source files
------------

// File: rtl/dynamic_preamble_filter_pkg.sv
// Shared OFDM receiver constants: default sizing and threshold helpers for the
// dynamic preamble filter.
package dynamic_preamble_filter_pkg;

    localparam int DPF_DATA_SIZE   = 48;
    localparam int DPF_MIN_POROG   = 1024;
    localparam int DPF_N_FILTR     = 5;
    localparam int DPF_POROG_SHIFT = 2;

endpackage

// File: rtl/dpf_window_mem.sv
// Circular sample window: each enabled cycle writes the new sample over the
// oldest slot and presents that evicted sample combinationally.
module dpf_window_mem #(
    parameter int DATA_SIZE = 48,
    parameter int N_FILTR   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] wr_data,
    output logic [DATA_SIZE-1:0] old_data
);

    localparam int DEPTH = 2 ** N_FILTR;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [N_FILTR-1:0]   ptr;

    // The slot under the pointer is always the oldest; empty slots read as zero.
    assign old_data = mem[ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr <= '0;
        end else if (en) begin
            mem[ptr] <= wr_data;
            ptr      <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dynamic_preamble_filter.sv
// Dynamic detection threshold: scaled moving average of correlator magnitude
// over a 2^N_FILTR window, saturated and floored at MIN_POROG.
module dynamic_preamble_filter
    import dynamic_preamble_filter_pkg::*;
#(
    parameter int DATA_SIZE   = DPF_DATA_SIZE,
    parameter int MIN_POROG   = DPF_MIN_POROG,
    parameter int N_FILTR     = DPF_N_FILTR,
    parameter int POROG_SHIFT = DPF_POROG_SHIFT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic [DATA_SIZE-1:0] out_porog
);

    localparam int SUM_W    = DATA_SIZE + N_FILTR;
    localparam int SCALED_W = DATA_SIZE + POROG_SHIFT;
    localparam logic [DATA_SIZE-1:0] FLOOR = DATA_SIZE'(MIN_POROG);

    logic [DATA_SIZE-1:0] oldest;
    logic [SUM_W-1:0]     sum;
    logic [DATA_SIZE-1:0] mean;
    logic [SCALED_W-1:0]  scaled;
    logic [DATA_SIZE-1:0] sat;
    logic [DATA_SIZE-1:0] next_porog;

    dpf_window_mem #(
        .DATA_SIZE (DATA_SIZE),
        .N_FILTR   (N_FILTR)
    ) u_window (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .wr_data  (in_data),
        .old_data (oldest)
    );

    // Threshold is derived from the sum held before the edge, giving a
    // two-edge latency from sample acceptance to out_porog.
    always_comb begin
        mean       = sum[SUM_W-1:N_FILTR];
        scaled     = SCALED_W'(mean) << POROG_SHIFT;
        sat        = scaled[DATA_SIZE-1:0];
        if (|(scaled >> DATA_SIZE)) sat = '1;
        next_porog = (sat < FLOOR) ? FLOOR : sat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum       <= '0;
            out_porog <= FLOOR;
        end else if (en) begin
            sum       <= sum + SUM_W'(in_data) - SUM_W'(oldest);
            out_porog <= next_porog;
        end
    end

endmodule

// File: tb/tb_dynamic_preamble_filter.sv
// Directed bench for dynamic_preamble_filter: reset, ramp, decay, saturation,
// enable freeze and mid-run reset, each against hand-derived thresholds.
module tb_dynamic_preamble_filter;

    localparam logic [47:0] MAXV = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [47:0] in_data = '0;
    logic [47:0] out_porog;

    int n_checks = 0;
    int n_fail   = 0;

    dynamic_preamble_filter dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_data   (in_data),
        .out_porog (out_porog)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs, take the edge, settle 1 time unit after it.
    task automatic step(input logic e, input logic [47:0] d);
        en = e;
        in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (out_porog !== 48'd1024) begin
            $display("FAIL reset_value: got %0d want 1024", out_porog);
            n_fail++;
        end
        // en and in_data must have no effect while reset is held
        en = 1'b1;
        in_data = 48'd4096;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_porog !== 48'd1024) begin
            $display("FAIL reset_ignores_en: got %0d want 1024", out_porog);
            n_fail++;
        end
        reset = 1'b1;
        en = 1'b0;
    endtask

    task automatic test_zero();
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 48'd0);
            n_checks++;
            if (out_porog !== 48'd1024) begin
                $display("FAIL zero_input[%0d]: got %0d want 1024", i, out_porog);
                n_fail++;
            end
        end
    endtask

    // After edge n of a 4096 ramp, out_porog reflects n-1 samples: 512*(n-1).
    task automatic ramp_check(input string name, input int edges);
        longint exp;
        for (int n = 1; n <= edges; n++) begin
            step(1'b1, 48'd4096);
            exp = 512 * ((n - 1 > 32) ? 32 : (n - 1));
            if (exp < 1024) exp = 1024;
            n_checks++;
            if (out_porog !== 48'(exp)) begin
                $display("FAIL %s[k=%0d]: got %0d want %0d", name, n - 1, out_porog, exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_ramp();
        apply_reset();
        ramp_check("ramp", 40);
    endtask

    // Continues from a full window of 4096: each zero edge j shows 512*(33-j).
    task automatic test_decay();
        longint exp;
        for (int j = 1; j <= 40; j++) begin
            step(1'b1, 48'd0);
            exp = (j <= 33) ? 512 * (33 - j) : 0;
            if (exp < 1024) exp = 1024;
            n_checks++;
            if (out_porog !== 48'(exp)) begin
                $display("FAIL decay[zeros=%0d]: got %0d want %0d", j - 1, out_porog, exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_saturate();
        logic [63:0] s, exp;
        apply_reset();
        for (int n = 1; n <= 40; n++) begin
            step(1'b1, MAXV);
            s   = 64'(n - 1) * 64'(MAXV);
            exp = (s >> 5) << 2;
            if (exp > 64'(MAXV)) exp = 64'(MAXV);
            if (exp < 64'd1024) exp = 64'd1024;
            n_checks++;
            if (out_porog !== exp[47:0]) begin
                $display("FAIL saturate[n=%0d]: got %h want %h", n, out_porog, exp[47:0]);
                n_fail++;
            end
        end
    endtask

    task automatic test_enable();
        apply_reset();
        for (int n = 0; n < 20; n++) step(1'b1, 48'd4096);
        n_checks++;
        if (out_porog !== 48'd9728) begin
            $display("FAIL en_pre: got %0d want 9728", out_porog);
            n_fail++;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 48'(i * 777777 + 123));
            n_checks++;
            if (out_porog !== 48'd9728) begin
                $display("FAIL en_freeze[%0d]: got %0d want 9728", i, out_porog);
                n_fail++;
            end
        end
        step(1'b1, 48'd4096);
        n_checks++;
        if (out_porog !== 48'd10240) begin
            $display("FAIL en_resume1: got %0d want 10240", out_porog);
            n_fail++;
        end
        step(1'b1, 48'd4096);
        n_checks++;
        if (out_porog !== 48'd10752) begin
            $display("FAIL en_resume2: got %0d want 10752", out_porog);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int n = 0; n < 35; n++) step(1'b1, 48'd4096);
        n_checks++;
        if (out_porog !== 48'd16384) begin
            $display("FAIL mid_pre: got %0d want 16384", out_porog);
            n_fail++;
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (out_porog !== 48'd1024) begin
            $display("FAIL mid_async: got %0d want 1024", out_porog);
            n_fail++;
        end
        @(posedge clk);
        #1 reset = 1'b1;
        ramp_check("mid_ramp", 40);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_ramp();
        test_decay();
        test_saturate();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
